// File: rtl/atm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : atm_pkg
// Purpose : Shared constants and types for the ATM UTOPIA-1 Rx cell scheduler.
//           Holds the cell size, port count, FSM state enum and port index
//           type, plus a small helper for round-robin pointer advance.
// Revision: 1.0 - initial release
// ============================================================================
package atm_pkg;

    localparam int NPORTS     = 4;
    localparam int CELL_BYTES = 53;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOC = 2'd1,
        XFER     = 2'd2
    } state_t;

    typedef logic [1:0] port_t;

    // Next port after p; the 2-bit index wraps naturally for four ports.
    function automatic port_t next_port(input port_t p);
        return p + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/atm_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : atm_rr_arbiter
// Purpose : Combinational round-robin pick. Searches the request vector
//           upward from ptr_i with wrap-around and returns the first
//           requesting port.
// Ports   : req_i  - per-port request vector
//           ptr_i  - port with highest priority this decision
//           gnt_o  - index of the selected port (valid when any_o = 1)
//           any_o  - at least one request is present
// Revision: 1.0 - initial release
// ============================================================================
module atm_rr_arbiter
    import atm_pkg::*;
#(
    parameter int NPORTS = atm_pkg::NPORTS
) (
    input  logic [NPORTS-1:0] req_i,
    input  port_t             ptr_i,
    output port_t             gnt_o,
    output logic              any_o
);

    // Scan from the farthest offset down to offset 0 so that the closest
    // requester to ptr_i is the last (winning) assignment.
    always_comb begin
        int w_idx;
        gnt_o = ptr_i;
        w_idx = 0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            w_idx = (int'(ptr_i) + i) % NPORTS;
            if (req_i[w_idx]) begin
                gnt_o = port_t'(w_idx);
            end
        end
    end

    assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/atm_rx_cell_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : atm_rx_cell_scheduler
// Purpose : Round-robin scheduler for four UTOPIA Level-1 Rx ports. Grants
//           one port at a time (only when downstream has room for a whole
//           cell), enables it for one 53-byte cell and forwards the bytes as
//           a single tagged stream. An unexpected start-of-cell mid-cell
//           aborts the cell with a cell_err pulse.
// Config  : `define ATM_RX_SOC_TIMEOUT_EN adds a start-of-cell timeout of
//           SOC_TIMEOUT enable cycles in WAIT_SOC (otherwise waits forever).
// Ports   : clk, rst (async, active-low)
//           Rx_data/Rx_soc/Rx_clav - per-port UTOPIA Rx inputs
//           Rx_en                  - per-port read enable (one-hot or zero)
//           dn_cell_rdy            - downstream can take one full cell
//           out_data/out_valid/out_soc/out_eoc/out_port - forwarded stream
//           cell_err               - one-cycle pulse on an aborted cell
// Revision: 1.0 - initial release
// ============================================================================
module atm_rx_cell_scheduler
    import atm_pkg::*;
#(
    parameter int NPORTS     = atm_pkg::NPORTS,
    parameter int CELL_BYTES = atm_pkg::CELL_BYTES
`ifdef ATM_RX_SOC_TIMEOUT_EN
    ,
    parameter int SOC_TIMEOUT = 16
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORTS*8-1:0] Rx_data,
    input  logic [NPORTS-1:0]   Rx_soc,
    input  logic [NPORTS-1:0]   Rx_clav,
    output logic [NPORTS-1:0]   Rx_en,
    input  logic                dn_cell_rdy,
    output logic [7:0]          out_data,
    output logic                out_valid,
    output logic                out_soc,
    output logic                out_eoc,
    output logic [1:0]          out_port,
    output logic                cell_err
);

    localparam int CNT_W = $clog2(CELL_BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(CELL_BYTES - 1);

    state_t            state_q, state_d;
    port_t             grant_q, grant_d;
    port_t             rr_q, rr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [NPORTS-1:0] en_q, en_d;
    logic [7:0]        odata_q, odata_d;
    port_t             oport_q, oport_d;
    logic              oval_q, oval_d;
    logic              osoc_q, osoc_d;
    logic              oeoc_q, oeoc_d;
    logic              err_q, err_d;

`ifdef ATM_RX_SOC_TIMEOUT_EN
    localparam int TO_W = $clog2(SOC_TIMEOUT + 1);
    logic [TO_W-1:0] to_q, to_d;
`endif

    port_t      w_gnt;
    logic       w_any;
    logic       w_soc;
    logic [7:0] w_byte;

    atm_rr_arbiter #(
        .NPORTS (NPORTS)
    ) u_arb (
        .req_i (Rx_clav),
        .ptr_i (rr_q),
        .gnt_o (w_gnt),
        .any_o (w_any)
    );

    // Only the granted port's lane is ever looked at.
    assign w_soc  = Rx_soc[grant_q];
    assign w_byte = Rx_data[{grant_q, 3'b000} +: 8];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        count_d = count_q;
        en_d    = en_q;
        odata_d = odata_q;
        oport_d = oport_q;
        oval_d  = 1'b0;
        osoc_d  = 1'b0;
        oeoc_d  = 1'b0;
        err_d   = 1'b0;
`ifdef ATM_RX_SOC_TIMEOUT_EN
        to_d    = to_q;
`endif
        case (state_q)
            IDLE: begin
                en_d    = '0;
                count_d = '0;
                // Downstream room and Clav are only looked at here.
                if (dn_cell_rdy && w_any) begin
                    grant_d = w_gnt;
                    en_d    = NPORTS'(1) << w_gnt;
                    state_d = WAIT_SOC;
`ifdef ATM_RX_SOC_TIMEOUT_EN
                    to_d    = '0;
`endif
                end
            end

            WAIT_SOC: begin
                if (w_soc) begin
                    odata_d = w_byte;
                    oport_d = grant_q;
                    oval_d  = 1'b1;
                    osoc_d  = 1'b1;
                    count_d = CNT_W'(1);
                    state_d = XFER;
                end
`ifdef ATM_RX_SOC_TIMEOUT_EN
                else if (to_q == TO_W'(SOC_TIMEOUT - 1)) begin
                    en_d    = '0;
                    err_d   = 1'b1;
                    rr_d    = next_port(grant_q);
                    state_d = IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
`endif
            end

            XFER: begin
                if (w_soc) begin
                    // Start-of-cell inside a cell: drop the byte and abort.
                    en_d    = '0;
                    err_d   = 1'b1;
                    count_d = '0;
                    rr_d    = next_port(grant_q);
                    state_d = IDLE;
                end else begin
                    odata_d = w_byte;
                    oport_d = grant_q;
                    oval_d  = 1'b1;
                    if (count_q == LAST_BYTE) begin
                        oeoc_d  = 1'b1;
                        en_d    = '0;
                        count_d = '0;
                        rr_d    = next_port(grant_q);
                        state_d = IDLE;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                en_d    = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            count_q <= '0;
            en_q    <= '0;
            odata_q <= '0;
            oport_q <= '0;
            oval_q  <= 1'b0;
            osoc_q  <= 1'b0;
            oeoc_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            count_q <= count_d;
            en_q    <= en_d;
            odata_q <= odata_d;
            oport_q <= oport_d;
            oval_q  <= oval_d;
            osoc_q  <= osoc_d;
            oeoc_q  <= oeoc_d;
            err_q   <= err_d;
        end
    end

`ifdef ATM_RX_SOC_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`endif

    assign Rx_en     = en_q;
    assign out_data  = odata_q;
    assign out_valid = oval_q;
    assign out_soc   = osoc_q;
    assign out_eoc   = oeoc_q;
    assign out_port  = oport_q;
    assign cell_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_atm_rx_cell_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_atm_rx_cell_scheduler
// Purpose : Self-checking bench for atm_rx_cell_scheduler. A behavioural
//           reference tracks the round-robin pointer and predicts the grant,
//           the enable pattern and the forwarded byte stream of each cell,
//           with random data, random noise on ignored inputs, random
//           soc delays, aborts and backpressure stalls.
// Revision: 1.0 - initial release
// ============================================================================
module tb_atm_rx_cell_scheduler;

    localparam int CB = 53;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Rx_data;
    logic [3:0]  Rx_soc;
    logic [3:0]  Rx_clav;
    logic [3:0]  Rx_en;
    logic        dn_cell_rdy;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_soc;
    logic        out_eoc;
    logic [1:0]  out_port;
    logic        cell_err;

    int checks = 0;
    int errors = 0;
    int rr     = 0;   // reference round-robin pointer

    atm_rx_cell_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .Rx_data     (Rx_data),
        .Rx_soc      (Rx_soc),
        .Rx_clav     (Rx_clav),
        .Rx_en       (Rx_en),
        .dn_cell_rdy (dn_cell_rdy),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_soc     (out_soc),
        .out_eoc     (out_eoc),
        .out_port    (out_port),
        .cell_err    (cell_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // First requesting port at or after the pointer, wrapping around.
    function automatic int pick(input logic [3:0] clav, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (clav[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [31:0] onehot(input int p);
        return 32'd1 << p;
    endfunction

    // Randomise inputs the DUT should ignore outside its decision points.
    task automatic noise();
        Rx_data     = $urandom;
        Rx_soc      = 4'($urandom);
        Rx_clav     = 4'($urandom);
        dn_cell_rdy = 1'($urandom);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"},    {28'd0, Rx_en}, 32'd0);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_soc"},   {31'd0, out_soc}, 32'd0);
        chk({tag, "_eoc"},   {31'd0, out_eoc}, 32'd0);
        chk({tag, "_err"},   {31'd0, cell_err}, 32'd0);
        chk({tag, "_data"},  {24'd0, out_data}, 32'd0);
        chk({tag, "_port"},  {30'd0, out_port}, 32'd0);
    endtask

    // Hold downstream not-ready for k cycles while Clav is asserted.
    task automatic idle_stall(input int k, input logic [3:0] clav);
        dn_cell_rdy = 1'b0;
        Rx_clav     = clav;
        Rx_soc      = 4'd0;
        repeat (k) begin
            @(negedge clk);
            chk("stall_en", {28'd0, Rx_en}, 32'd0);
            chk("stall_valid", {31'd0, out_valid}, 32'd0);
        end
    endtask

    // Entered at a negedge with the DUT idle. abort_at / rst_at: byte index
    // at which an early soc / a reset is applied (-1 for none).
    task automatic run_cell(input logic [3:0] clav, input int soc_delay,
                            input int abort_at, input int rst_at, input bit seq);
        int         g;
        logic [7:0] b;
        g           = pick(clav, rr);
        Rx_clav     = clav;
        dn_cell_rdy = 1'b1;
        Rx_soc      = 4'd0;
        @(negedge clk);
        chk("grant_en", {28'd0, Rx_en}, onehot(g));
        chk("grant_valid", {31'd0, out_valid}, 32'd0);
        for (int d = 0; d < soc_delay; d++) begin
            noise();
            Rx_soc[g] = 1'b0;
            @(negedge clk);
            chk("wait_en", {28'd0, Rx_en}, onehot(g));
            chk("wait_valid", {31'd0, out_valid}, 32'd0);
        end
        for (int i = 0; i < CB; i++) begin
            noise();
            b = seq ? 8'(i) : 8'($urandom);
            Rx_data[g*8 +: 8] = b;
            Rx_soc[g]         = (i == 0) || (i == abort_at);
            if (i == rst_at) begin
                #2 rst = 1'b0;
                #1 chk_all_zero("midrst");
                @(negedge clk);
                rst     = 1'b1;
                rr      = 0;
                Rx_soc  = 4'd0;
                Rx_clav = 4'd0;
                return;
            end
            @(negedge clk);
            if (i == abort_at) begin
                chk("abort_err",   {31'd0, cell_err}, 32'd1);
                chk("abort_valid", {31'd0, out_valid}, 32'd0);
                chk("abort_eoc",   {31'd0, out_eoc}, 32'd0);
                chk("abort_en",    {28'd0, Rx_en}, 32'd0);
                rr = (g + 1) % 4;
                return;
            end
            chk("valid", {31'd0, out_valid}, 32'd1);
            chk("data",  {24'd0, out_data}, {24'd0, b});
            chk("flags", {29'd0, out_soc, out_eoc, cell_err},
                {29'd0, (i == 0), (i == CB - 1), 1'b0});
            chk("port",  {30'd0, out_port}, 32'(g));
            chk("en",    {28'd0, Rx_en}, (i == CB - 1) ? 32'd0 : onehot(g));
        end
        rr = (g + 1) % 4;
    endtask

    initial begin
        rst         = 1'b0;
        Rx_data     = '0;
        Rx_soc      = '0;
        Rx_clav     = '0;
        dn_cell_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Single cell on port 2 with bytes 0x00..0x34.
        run_cell(4'b0100, 1, -1, -1, 1'b1);

        // Backpressure then release on port 0.
        idle_stall(20, 4'b0001);
        run_cell(4'b0001, 1, -1, -1, 1'b0);

        // Early soc from port 1 at byte 20; next grant must come from port 2.
        run_cell(4'b0010, 1, 20, -1, 1'b0);
        run_cell(4'hF, 1, -1, -1, 1'b0);

        // Randomised traffic.
        for (int n = 0; n < 25; n++) begin
            logic [3:0] clav;
            int         ab;
            clav = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0) idle_stall($urandom_range(1, 5), clav);
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, CB - 1)) : -1;
            run_cell(clav, $urandom_range(0, 3), ab, -1, 1'b0);
        end

        // Reset mid-cell at byte 30, then fairness from port 0.
        run_cell(4'b0100, 1, -1, 30, 1'b0);
        for (int n = 0; n < 5; n++) begin
            run_cell(4'hF, 1, -1, -1, 1'b0);
        end

        // Port 3 never sends soc.
        Rx_clav     = 4'b1000;
        dn_cell_rdy = 1'b1;
        Rx_soc      = 4'd0;
        @(negedge clk);
        chk("to_en_first", {28'd0, Rx_en}, 32'h8);
`ifdef ATM_RX_SOC_TIMEOUT_EN
        for (int j = 2; j <= 16; j++) begin
            noise();
            Rx_soc[3] = 1'b0;
            @(negedge clk);
            chk("to_en", {28'd0, Rx_en}, 32'h8);
            chk("to_err_early", {31'd0, cell_err}, 32'd0);
        end
        noise();
        Rx_soc[3] = 1'b0;
        @(negedge clk);
        chk("to_err", {31'd0, cell_err}, 32'd1);
        chk("to_en_drop", {28'd0, Rx_en}, 32'd0);
        rr = 0;
        run_cell(4'hF, 1, -1, -1, 1'b0);
`else
        for (int j = 0; j < 40; j++) begin
            noise();
            Rx_soc[3] = 1'b0;
            @(negedge clk);
            chk("nto_en", {28'd0, Rx_en}, 32'h8);
            chk("nto_err", {31'd0, cell_err}, 32'd0);
        end
        rst = 1'b0;
        #1 chk("nto_rst_en", {28'd0, Rx_en}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        rr  = 0;
        run_cell(4'hF, 1, -1, -1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/atm_rx_cell_scheduler.md
# atm_rx_cell_scheduler

Round-robin scheduler for the four UTOPIA Level-1 Rx interfaces of the ATM router. It polls each port's cell-available flag and grants one port at a time. It drives that port's enable for exactly one 53-byte cell and forwards the bytes as a single tagged stream toward the router's cell buffer. A new cell starts only when downstream signals room for a whole cell.

## Interface
- NPORTS, 4: number of Rx ports.
- CELL_BYTES, 53: bytes per ATM cell.
- SOC_TIMEOUT, 16: cycles allowed from enable to start-of-cell (used only with the macro).

- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- Rx_data  input  NPORTS*8  per-port Rx byte; port p occupies bits [8p+7:8p].
- Rx_soc  input  NPORTS  per-port start-of-cell flag.
- Rx_clav  input  NPORTS  per-port cell-available flag.
- Rx_en  output  NPORTS  per-port read enable, active-high, one-hot or zero.
- dn_cell_rdy  input  1  downstream can accept one full cell.
- out_data  output  8  forwarded byte.
- out_valid  output  1  out_data is valid this cycle.
- out_soc  output  1  first byte of a cell, qualified by out_valid.
- out_eoc  output  1  byte CELL_BYTES-1 of a cell, qualified by out_valid.
- out_port  output  2  source port of the current byte.
- cell_err  output  1  one-cycle pulse on an aborted cell.

## Operation
- States: IDLE, WAIT_SOC, XFER.
- IDLE:
  - Rx_en = 0.
  - If dn_cell_rdy = 1 and any Rx_clav bit = 1, grant the first requesting port searching upward, with wrap-around, from rr_ptr. Register the grant and go to WAIT_SOC.
- WAIT_SOC:
  - Rx_en[grant] = 1.
  - A byte is accepted in any cycle where Rx_en[grant] = 1 and Rx_soc[grant] = 1. On acceptance, forward it as byte 0, set count = 1, and go to XFER.
  - Bytes without soc are ignored.
- XFER:
  - Rx_en[grant] = 1.
  - Each cycle accepts one byte and increments count.
  - When count = CELL_BYTES-1, that byte is forwarded with out_eoc = 1. Then Rx_en drops, rr_ptr = grant+1 mod NPORTS, and the FSM returns to IDLE.
- Soc seen in XFER at any count other than 0:
  - Abort: pulse cell_err, do not forward the byte, and drop Rx_en.
  - Return to IDLE and set rr_ptr = grant+1.
  - The downstream sees a cell with out_soc but no out_eoc and discards it on cell_err.
- dn_cell_rdy is sampled only in IDLE. Deassertion during a cell has no effect.
- Rx_clav is sampled only in IDLE. Its value during a transfer is ignored.
- count is ceil(log2(CELL_BYTES)) bits wide and never exceeds CELL_BYTES-1.

## Timing
- Reset values:
  - Rx_en = 0, out_valid = 0, out_soc = 0, out_eoc = 0, cell_err = 0, out_data = 0, out_port = 0.
  - FSM = IDLE, rr_ptr = 0, count = 0.
- Grant-to-enable latency: Rx_en rises the cycle after the IDLE grant decision.
- All outputs are registered. A byte accepted in cycle n appears on out_data/out_valid in cycle n+1.
- Throughput: one byte per cycle in XFER.
- Minimum gap between cells is 1 IDLE cycle, so back-to-back cells cost CELL_BYTES+2 cycles including the enable cycle before soc.
- Simultaneous soc and eoc cannot occur (CELL_BYTES > 1).
- Reset asserted mid-cell returns everything to reset values immediately. No cell_err is issued and no partial eoc is produced.

## Configuration
- Macro: ATM_RX_SOC_TIMEOUT_EN.
- When defined: a counter runs in WAIT_SOC. If soc has not arrived after SOC_TIMEOUT cycles of Rx_en, the block drops Rx_en, pulses cell_err, sets rr_ptr = grant+1, and returns to IDLE.
- When undefined: WAIT_SOC waits indefinitely, and the counter and the SOC_TIMEOUT parameter logic are not built.

## Structure
- Package atm_pkg holds:
  - CELL_BYTES constant.
  - state enum {IDLE, WAIT_SOC, XFER}.
  - port index typedef (logic [1:0]).
- One sub-module, atm_rr_arbiter: combinational round-robin pick from request vector and rr_ptr, returning a grant index and an any-request flag.
- FSM, counters and output registers live in the top block.

## Test plan
- Single cell: Rx_clav = 4'b0100 and dn_cell_rdy = 1, with port 2 sending soc and then bytes 0x00..0x34.
  - Rx_en = 4'b0100 for exactly 53 accepted bytes.
  - out_port = 2; out_soc on 0x00; out_eoc on 0x34; no cell_err.
- Fairness: Rx_clav = 4'hF held for 5 cells → grant order 0,1,2,3,0, with one IDLE cycle between cells.
- Backpressure: dn_cell_rdy = 0 with Rx_clav = 4'h1 for 20 cycles → Rx_en stays 0. Raising dn_cell_rdy produces Rx_en[0] on the following cycle.
- Early soc: port 1 reasserts soc on byte 20 → cell_err pulses once, no out_eoc, Rx_en drops, next grant is from port 2.
- Timeout (macro defined, SOC_TIMEOUT = 16): port 3 never asserts soc → cell_err at the 16th enable cycle, then IDLE. With the macro undefined, Rx_en[3] stays high indefinitely.
- Reset mid-cell: rst low at byte 30 → all outputs are 0 within the same cycle. After release, the next grant starts from port 0.
